// File: rtl/uch_pkg.sv
// rtl/uch_pkg.sv - shared constants for the uch counter control front-end
package uch_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/uch_debounce.sv
// rtl/uch_debounce.sv - button synchronizer, debouncer and registered rising-edge pulse
module uch_debounce
  import uch_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The flip happens on the DB_CYCLES-th consecutive mismatch, so the counter only reaches DB_CYCLES-1.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      rise_q      <= rise_d;
      cnt_q       <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/uch_ctrl.sv
// rtl/uch_ctrl.sv - run/direction control FSM with terminal-count auto-stop for the uch counter
module uch_ctrl
  import uch_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int AUTO_STOP = 1
) (
  input  logic             uch_ctrl_clk,
  input  logic             uch_ctrl_rst,
  input  logic             uch_ctrl_run,
  input  logic             uch_ctrl_dir,
  input  logic [CNT_W-1:0] uch_ctrl_q,
  output logic             uch_ctrl_en,
  output logic             uch_ctrl_sel,
  output logic             uch_ctrl_lim
);

  localparam logic             AS_EN   = (AUTO_STOP != 0);
  localparam logic [CNT_W-1:0] Q_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] Q_MAXM1 = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] Q_ONE   = CNT_W'(1);

  logic             run_lvl_unused, dir_lvl_unused;
  logic             run_rise, dir_rise;
  logic [1:0]       state_q, state_d;
  logic             sel_q, sel_d;
  logic             en_q, en_d;
  logic             lim_q, lim_d;
  logic [CNT_W-1:0] term_val, appr_val;

  uch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .clk   (uch_ctrl_clk),
    .rst   (uch_ctrl_rst),
    .raw   (uch_ctrl_run),
    .level (run_lvl_unused),
    .rise  (run_rise)
  );

  uch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
    .clk   (uch_ctrl_clk),
    .rst   (uch_ctrl_rst),
    .raw   (uch_ctrl_dir),
    .level (dir_lvl_unused),
    .rise  (dir_rise)
  );

  // Terminal and approach compares use the post-toggle direction so a same-cycle dir press is honoured.
  always_comb begin
    sel_d    = sel_q ^ dir_rise;
    term_val = (sel_d == DIR_UP) ? Q_MAX   : '0;
    appr_val = (sel_d == DIR_UP) ? Q_MAXM1 : Q_ONE;
    state_d  = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run_rise && !(AS_EN && (uch_ctrl_q == term_val))) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (run_rise)                                          state_d = ST_IDLE;
        else if (AS_EN && en_q && (uch_ctrl_q == appr_val))    state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (run_rise)      state_d = ST_IDLE;
        else if (dir_rise) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    en_d  = (state_d == ST_RUN);
    lim_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge uch_ctrl_clk or negedge uch_ctrl_rst) begin
    if (!uch_ctrl_rst) begin
      state_q <= ST_IDLE;
      sel_q   <= DIR_UP;
      en_q    <= 1'b0;
      lim_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      lim_q   <= lim_d;
    end
  end

  assign uch_ctrl_en  = en_q;
  assign uch_ctrl_sel = sel_q;
  assign uch_ctrl_lim = lim_q;

endmodule

// File: tb/tb_uch_ctrl.sv
// tb/tb_uch_ctrl.sv - self-checking bench: two uch_ctrl loops (auto-stop on/off) against a behavioural model
module tb_uch_ctrl;

  localparam int DB = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       raw_run, raw_dir;
  logic [3:0] q0, q1;
  logic       en0, sel0, lim0, en1, sel1, lim1;

  int n_checks = 0;
  int n_errors = 0;

  logic          m_d1[2], m_d2[2], m_lvl[2], m_p1[2], m_p2[2];
  logic [DB-1:0] m_win[2];
  int            m_st[2];
  logic          m_sel[2];
  logic [3:0]    m_q[2];

  always #5 clk = ~clk;

  uch_ctrl #(.DB_CYCLES(DB), .CNT_W(4), .AUTO_STOP(1)) u_dut0 (
    .uch_ctrl_clk (clk),
    .uch_ctrl_rst (rst_n),
    .uch_ctrl_run (raw_run),
    .uch_ctrl_dir (raw_dir),
    .uch_ctrl_q   (q0),
    .uch_ctrl_en  (en0),
    .uch_ctrl_sel (sel0),
    .uch_ctrl_lim (lim0)
  );

  uch_ctrl #(.DB_CYCLES(DB), .CNT_W(4), .AUTO_STOP(0)) u_dut1 (
    .uch_ctrl_clk (clk),
    .uch_ctrl_rst (rst_n),
    .uch_ctrl_run (raw_run),
    .uch_ctrl_dir (raw_dir),
    .uch_ctrl_q   (q1),
    .uch_ctrl_en  (en1),
    .uch_ctrl_sel (sel1),
    .uch_ctrl_lim (lim1)
  );

  // Stand-in for the uch up/down counter closing each loop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0 <= 4'd0;
      q1 <= 4'd0;
    end else begin
      if (en0) q0 <= sel0 ? q0 + 4'd1 : q0 - 4'd1;
      if (en1) q1 <= sel1 ? q1 + 4'd1 : q1 - 4'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_d1[b] = 1'b0; m_d2[b] = 1'b0; m_lvl[b] = 1'b0;
      m_p1[b] = 1'b0; m_p2[b] = 1'b0; m_win[b] = '0;
      m_st[b] = M_IDLE; m_sel[b] = 1'b1; m_q[b] = 4'd0;
    end
  endtask

  // A debounced level flips once the last DB synchronized samples all disagree with it;
  // the FSM sees that rise two edges later.
  task automatic model_step();
    logic act[2];
    logic raws[2];
    logic x, ns;
    logic [3:0] qp, term, appr;
    raws[0] = raw_run;
    raws[1] = raw_dir;
    for (int b = 0; b < 2; b++) begin
      act[b]  = m_p2[b];
      m_p2[b] = m_p1[b];
      x       = m_d2[b];
      m_d2[b] = m_d1[b];
      m_d1[b] = raws[b];
      m_win[b] = {m_win[b][DB-2:0], x};
      m_p1[b] = 1'b0;
      if (m_win[b] == {DB{~m_lvl[b]}}) begin
        m_lvl[b] = ~m_lvl[b];
        m_p1[b]  = m_lvl[b];
      end
    end
    for (int i = 0; i < 2; i++) begin
      qp = m_q[i];
      if (m_st[i] == M_RUN) m_q[i] = m_sel[i] ? qp + 4'd1 : qp - 4'd1;
      ns   = m_sel[i] ^ act[1];
      term = ns ? 4'd15 : 4'd0;
      appr = ns ? 4'd14 : 4'd1;
      case (m_st[i])
        M_IDLE: if (act[0] && !(i == 0 && qp == term)) m_st[i] = M_RUN;
        M_RUN: begin
          if (act[0])                     m_st[i] = M_IDLE;
          else if (i == 0 && qp == appr)  m_st[i] = M_HOLD;
        end
        default: begin
          if (act[0])      m_st[i] = M_IDLE;
          else if (act[1]) m_st[i] = M_RUN;
        end
      endcase
      m_sel[i] = ns;
    end
  endtask

  task automatic compare_all();
    check("en_as1",  en0,  m_st[0] == M_RUN);
    check("sel_as1", sel0, m_sel[0]);
    check("lim_as1", lim0, m_st[0] == M_HOLD);
    check("q_as1",   q0,   m_q[0]);
    check("en_as0",  en1,  m_st[1] == M_RUN);
    check("sel_as0", sel1, m_sel[1]);
    check("lim_as0", lim1, 1'b0);
    check("q_as0",   q1,   m_q[1]);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic press_run(input int len);
    raw_run = 1'b1;
    repeat (len) step();
    raw_run = 1'b0;
    repeat (DB + 4) step();
  endtask

  task automatic press_dir(input int len);
    raw_dir = 1'b1;
    repeat (len) step();
    raw_dir = 1'b0;
    repeat (DB + 4) step();
  endtask

  task automatic wait_lim0(input string tag);
    int n;
    n = 0;
    while (!lim0 && n < 40) begin
      step();
      n++;
    end
    check(tag, lim0, 1'b1);
  endtask

  // Asserted half-way between edges; outputs must drop before the next edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_en"},  en0,  1'b0);
    check({tag, "_sel"}, sel0, 1'b1);
    check({tag, "_lim"}, lim0, 1'b0);
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int hold_run, hold_dir;

    rst_n   = 1'b0;
    raw_run = 1'b0;
    raw_dir = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_en",  en0,  1'b0);
    check("rst_sel", sel0, 1'b1);
    check("rst_lim", lim0, 1'b0);
    check("rst_q",   q0,   4'd0);
    rst_n = 1'b1;
    repeat (20) step();

    raw_run = 1'b1;
    cnt = 0;
    while (!en0 && cnt < 20) begin
      step();
      cnt++;
    end
    check("run_latency", cnt, DB + 4);
    check("run_sel", sel0, 1'b1);
    repeat (10 - cnt) step();
    raw_run = 1'b0;

    wait_lim0("reach_hold_up");
    check("hold_up_q", q0, 4'd15);
    check("hold_up_en", en0, 1'b0);
    repeat (20) step();
    check("hold_up_stays", q0, 4'd15);

    for (int k = 0; k < 4; k++) begin
      raw_run = (k % 2 == 0);
      step();
    end
    raw_run = 1'b0;
    repeat (12) step();
    check("bounce_keeps_hold", lim0, 1'b1);

    raw_dir = 1'b1;
    repeat (DB + 4) step();
    check("dir_from_hold_en", en0, 1'b1);
    check("dir_from_hold_sel", sel0, 1'b0);
    repeat (2) step();
    raw_dir = 1'b0;
    wait_lim0("reach_hold_dn");
    check("hold_dn_q", q0, 4'd0);

    press_run(10);
    check("hold_to_idle", en0 | lim0, 1'b0);
    press_run(10);
    check("idle_at_term_stays", en0, 1'b0);
    press_dir(10);
    check("idle_dir_toggle", sel0, 1'b1);
    press_run(6);
    check("rerun_en", en0, 1'b1);
    async_reset("midrun_rst");
    press_run(10);
    check("after_rst_run", en0, 1'b1);

    hold_run = 1;
    hold_dir = 1;
    for (int c = 0; c < 4000; c++) begin
      if (--hold_run == 0) begin
        raw_run  = ~raw_run;
        hold_run = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 40);
      end
      if (--hold_dir == 0) begin
        raw_dir  = ~raw_dir;
        hold_dir = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 60);
      end
      if ($urandom_range(0, 999) == 0) async_reset("rand_rst");
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
